// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer: command codes, FSM states
// and FIFO geometry.
// Ports: none (package).
package lcd_pkg;

  // Command FIFO geometry
  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_AW    = 3;

  // Host command codes; 12..15 are not defined and get dropped
  localparam logic [3:0] CMD_WRITE = 4'd0;
  localparam logic [3:0] CMD_UP    = 4'd1;
  localparam logic [3:0] CMD_DOWN  = 4'd2;
  localparam logic [3:0] CMD_LEFT  = 4'd3;
  localparam logic [3:0] CMD_RIGHT = 4'd4;
  localparam logic [3:0] CMD_MAX   = 4'd5;
  localparam logic [3:0] CMD_MIN   = 4'd6;
  localparam logic [3:0] CMD_AVG   = 4'd7;
  localparam logic [3:0] CMD_CCW   = 4'd8;
  localparam logic [3:0] CMD_CW    = 4'd9;
  localparam logic [3:0] CMD_MIRX  = 4'd10;
  localparam logic [3:0] CMD_MIRY  = 4'd11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    ACK    = 3'd2,
    FLUSH  = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Codes above MIRY have no meaning for the LCD controller
  function automatic logic cmd_is_illegal(input logic [3:0] cmd);
    return cmd > CMD_MIRY;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous 8-deep, 4-bit command FIFO with occupancy output.
// Ports: clk/reset; push + push_data write side; pop + pop_data (head, combinational)
//        read side; level (0..8), empty, full status.
module lcd_cmd_fifo
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [3:0] push_data,
  input  logic       pop,
  output logic [3:0] pop_data,
  output logic [3:0] level,
  output logic       empty,
  output logic       full
);

  logic [3:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty    = (level == 4'd0);
  assign full     = (level == 4'(FIFO_DEPTH));
  assign pop_data = mem[rd_ptr];

  // A push into a full FIFO is still safe when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers are exactly FIFO_AW bits wide, so increment wraps modulo depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 4'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 4'd1;
        2'b01:   level <= level - 4'd1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lcd_cmd_seq.sv
// Buffers host commands and issues them one at a time to the LCD controller,
// honouring its busy handshake; a WRITE command flushes and ends the sequence.
// Ports: clk/reset (async, active-high); host_cmd/host_valid/host_ready host side;
//        lcd_cmd/lcd_cmd_valid/lcd_busy/lcd_done controller side; seq_done (sticky),
//        err_illegal (pulse), fifo_level status. Optional output timeout exists
//        only when LCD_CMD_SEQ_TIMEOUT_EN is defined (8-bit ACK/FLUSH watchdog).
module lcd_cmd_seq
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] host_cmd,
  input  logic       host_valid,
  output logic       host_ready,
  output logic [3:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  input  logic       lcd_busy,
  input  logic       lcd_done,
  output logic       seq_done,
  output logic       err_illegal,
`ifdef LCD_CMD_SEQ_TIMEOUT_EN
  output logic       timeout,
`endif
  output logic [3:0] fifo_level
);

  state_t     state;
  logic       push;
  logic       pop;
  logic [3:0] head;
  logic       fifo_empty;
  logic       fifo_full;

  // Once finished, the host is refused so nothing more piles up behind WRITE
  assign host_ready = !fifo_full && (state != FINISH);
  assign push       = host_valid && host_ready;

  // Head is only taken while the controller is idle, so no issue can overlap busy
  assign pop = (state == IDLE) && !fifo_empty && !lcd_busy;

  lcd_cmd_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (host_cmd),
    .pop       (pop),
    .pop_data  (head),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

`ifdef LCD_CMD_SEQ_TIMEOUT_EN
  logic [7:0] wd_cnt;
  // The wait has lasted 255 cycles once this cycle's count would make 255
  logic       wd_expire;
  assign wd_expire = (wd_cnt == 8'd254);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      lcd_cmd       <= CMD_WRITE;
      lcd_cmd_valid <= 1'b0;
      seq_done      <= 1'b0;
      err_illegal   <= 1'b0;
`ifdef LCD_CMD_SEQ_TIMEOUT_EN
      wd_cnt        <= 8'd0;
      timeout       <= 1'b0;
`endif
    end else begin
      lcd_cmd_valid <= 1'b0;
      err_illegal   <= 1'b0;
`ifdef LCD_CMD_SEQ_TIMEOUT_EN
      // Counts waiting cycles; every state transition below clears it again
      wd_cnt <= (state == ACK || state == FLUSH) ? wd_cnt + 8'd1 : 8'd0;
`endif
      case (state)
        IDLE: begin
          if (pop) begin
            if (cmd_is_illegal(head)) begin
              err_illegal <= 1'b1;
            end else begin
              lcd_cmd       <= head;
              lcd_cmd_valid <= 1'b1;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= (lcd_cmd == CMD_WRITE) ? FLUSH : ACK;
        end
        ACK: begin
          // Always at least one cycle here, which spans the controller raising busy
          if (!lcd_busy) begin
            state <= IDLE;
`ifdef LCD_CMD_SEQ_TIMEOUT_EN
            wd_cnt <= 8'd0;
          end else if (wd_expire) begin
            state    <= FINISH;
            seq_done <= 1'b1;
            timeout  <= 1'b1;
            wd_cnt   <= 8'd0;
`endif
          end
        end
        FLUSH: begin
          if (lcd_done) begin
            state    <= FINISH;
            seq_done <= 1'b1;
`ifdef LCD_CMD_SEQ_TIMEOUT_EN
            wd_cnt   <= 8'd0;
          end else if (wd_expire) begin
            state    <= FINISH;
            seq_done <= 1'b1;
            timeout  <= 1'b1;
            wd_cnt   <= 8'd0;
`endif
          end
        end
        FINISH: begin
          // Terminal: anything left in the FIFO stays unissued
          seq_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
module tb_lcd_cmd_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] host_cmd = 4'd0;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       lcd_busy = 1'b0;
  logic       lcd_done = 1'b0;
  logic       seq_done;
  logic       err_illegal;
  logic [3:0] fifo_level;
`ifdef LCD_CMD_SEQ_TIMEOUT_EN
  logic       timeout;
`endif

  // Standalone FIFO instance for the full-level push/pop case
  logic       f_push = 1'b0;
  logic [3:0] f_push_data = 4'd0;
  logic       f_pop = 1'b0;
  logic [3:0] f_pop_data;
  logic [3:0] f_level;
  logic       f_empty;
  logic       f_full;

  int checks = 0;
  int errors = 0;

  // Per-cycle recording (filled by tick)
  int         cyc;
  logic [3:0] issued[$];
  int         issue_at[$];
  int         rises;
  int         err_cnt;
  int         err_at;
  logic       prev_valid;
  logic       busy_model;

  always #5 clk = ~clk;

  lcd_cmd_seq dut (
    .clk           (clk),
    .reset         (reset),
    .host_cmd      (host_cmd),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .lcd_cmd       (lcd_cmd),
    .lcd_cmd_valid (lcd_cmd_valid),
    .lcd_busy      (lcd_busy),
    .lcd_done      (lcd_done),
    .seq_done      (seq_done),
    .err_illegal   (err_illegal),
`ifdef LCD_CMD_SEQ_TIMEOUT_EN
    .timeout       (timeout),
`endif
    .fifo_level    (fifo_level)
  );

  lcd_cmd_fifo u_fifo_chk (
    .clk       (clk),
    .reset     (reset),
    .push      (f_push),
    .push_data (f_push_data),
    .pop       (f_pop),
    .pop_data  (f_pop_data),
    .level     (f_level),
    .empty     (f_empty),
    .full      (f_full)
  );

  // Advance to the next falling edge, record outputs, then (optionally) model
  // the controller raising busy for the one cycle after each issue cycle.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (lcd_cmd_valid) begin
      issued.push_back(lcd_cmd);
      issue_at.push_back(cyc);
      if (!prev_valid) rises++;
    end
    if (err_illegal) begin
      err_cnt++;
      err_at = cyc;
    end
    if (busy_model) lcd_busy = prev_valid;
    prev_valid = lcd_cmd_valid;
  endtask

  task automatic do_reset(input logic model_en, input logic busy_val);
    @(negedge clk);
    reset      = 1'b1;
    host_valid = 1'b0;
    host_cmd   = 4'd0;
    lcd_done   = 1'b0;
    lcd_busy   = busy_val;
    busy_model = model_en;
    @(negedge clk);
    reset      = 1'b0;
    cyc        = 0;
    issued.delete();
    issue_at.delete();
    rises      = 0;
    err_cnt    = 0;
    err_at     = -1;
    prev_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if (lcd_cmd !== 4'd0) begin errors++; $display("FAIL reset_lcd_cmd: got %0d expected 0", lcd_cmd); end
    checks++; if (lcd_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", lcd_cmd_valid); end
    checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL reset_seq_done: got %b expected 0", seq_done); end
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_illegal); end
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL reset_host_ready: got %b expected 1", host_ready); end
`ifdef LCD_CMD_SEQ_TIMEOUT_EN
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
`endif
    reset = 1'b0;
  endtask

  // Push 4 then 1; controller busy one cycle per command
  task automatic test_issue_pair();
    do_reset(1'b1, 1'b0);
    host_valid = 1'b1; host_cmd = 4'd4;
    tick();
    host_cmd = 4'd1;
    tick();
    host_valid = 1'b0;
    repeat (20) tick();
    checks++; if (issued.size() !== 2) begin errors++; $display("FAIL pair_count: got %0d issues expected 2", issued.size()); end
    checks++; if (rises !== 2) begin errors++; $display("FAIL pair_pulses: got %0d rising edges expected 2", rises); end
    if (issued.size() == 2) begin
      checks++; if (issued[0] !== 4'd4) begin errors++; $display("FAIL pair_first_cmd: got %0d expected 4", issued[0]); end
      checks++; if (issued[1] !== 4'd1) begin errors++; $display("FAIL pair_second_cmd: got %0d expected 1", issued[1]); end
      checks++; if (issue_at[0] !== 2) begin errors++; $display("FAIL pair_latency: got cycle %0d expected 2", issue_at[0]); end
    end
    checks++; if (lcd_cmd !== 4'd1) begin errors++; $display("FAIL pair_cmd_hold: got %0d expected 1", lcd_cmd); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL pair_level: got %0d expected 0", fifo_level); end
  endtask

  // Busy held for 70 cycles after reset; head waits, issues 2 cycles after the last busy cycle
  task automatic test_busy_hold();
    do_reset(1'b0, 1'b1);
    host_valid = 1'b1; host_cmd = 4'd5;
    tick();
    host_valid = 1'b0;
    while (cyc < 70) tick();
    checks++; if (issued.size() !== 0) begin errors++; $display("FAIL busy_no_issue: got %0d issues expected 0", issued.size()); end
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL busy_level: got %0d expected 1", fifo_level); end
    lcd_busy = 1'b0;
    repeat (5) tick();
    checks++; if (issued.size() !== 1) begin errors++; $display("FAIL busy_count: got %0d issues expected 1", issued.size()); end
    if (issued.size() == 1) begin
      checks++; if (issued[0] !== 4'd5) begin errors++; $display("FAIL busy_cmd: got %0d expected 5", issued[0]); end
      checks++; if (issue_at[0] !== 71) begin errors++; $display("FAIL busy_latency: got cycle %0d expected 71", issue_at[0]); end
    end
  endtask

  // Fill 8 entries with busy held, try a ninth, then drain
  task automatic test_fifo_full();
    do_reset(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      host_valid = 1'b1; host_cmd = 4'(i + 1);
      tick();
    end
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_level: got %0d expected 8", fifo_level); end
    checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", host_ready); end
    host_cmd = 4'd9;
    tick();
    host_valid = 1'b0;
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_ninth: got level %0d expected 8", fifo_level); end
    busy_model = 1'b1;
    repeat (60) tick();
    checks++; if (issued.size() !== 8) begin errors++; $display("FAIL full_drain_count: got %0d issues expected 8", issued.size()); end
    if (issued.size() == 8) begin
      checks++; if (issued[0] !== 4'd1) begin errors++; $display("FAIL full_drain_first: got %0d expected 1", issued[0]); end
      checks++; if (issued[7] !== 4'd8) begin errors++; $display("FAIL full_drain_last: got %0d expected 8", issued[7]); end
    end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL full_drain_level: got %0d expected 0", fifo_level); end
  endtask

  // Simultaneous push and pop at level 8 on the FIFO itself, with pointer wrap
  task automatic test_fifo_push_pop_full();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      f_push = 1'b1; f_push_data = 4'(i + 1);
      tick();
    end
    checks++; if (f_level !== 4'd8) begin errors++; $display("FAIL ff_level: got %0d expected 8", f_level); end
    checks++; if (f_full !== 1'b1) begin errors++; $display("FAIL ff_full: got %b expected 1", f_full); end
    checks++; if (f_pop_data !== 4'd1) begin errors++; $display("FAIL ff_head: got %0d expected 1", f_pop_data); end
    f_push = 1'b1; f_push_data = 4'd15; f_pop = 1'b1;
    tick();
    checks++; if (f_level !== 4'd8) begin errors++; $display("FAIL ff_pushpop_level: got %0d expected 8", f_level); end
    checks++; if (f_pop_data !== 4'd2) begin errors++; $display("FAIL ff_pushpop_head: got %0d expected 2", f_pop_data); end
    f_push = 1'b0;
    repeat (7) tick();
    f_pop = 1'b0;
    checks++; if (f_level !== 4'd1) begin errors++; $display("FAIL ff_wrap_level: got %0d expected 1", f_level); end
    checks++; if (f_pop_data !== 4'd15) begin errors++; $display("FAIL ff_wrap_data: got %0d expected 15", f_pop_data); end
  endtask

  // Illegal 13 dropped with one err pulse, then 7 issued
  task automatic test_illegal();
    do_reset(1'b1, 1'b0);
    host_valid = 1'b1; host_cmd = 4'd13;
    tick();
    host_cmd = 4'd7;
    tick();
    host_valid = 1'b0;
    repeat (15) tick();
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL illegal_pulses: got %0d cycles expected 1", err_cnt); end
    checks++; if (err_at !== 2) begin errors++; $display("FAIL illegal_when: got cycle %0d expected 2", err_at); end
    checks++; if (issued.size() !== 1) begin errors++; $display("FAIL illegal_issue_count: got %0d expected 1", issued.size()); end
    if (issued.size() == 1) begin
      checks++; if (issued[0] !== 4'd7) begin errors++; $display("FAIL illegal_issued_cmd: got %0d expected 7", issued[0]); end
    end
  endtask

  // WRITE flushes: done at cycle 66 finishes the sequence, 3 stays unissued
  task automatic test_flush_finish();
    do_reset(1'b1, 1'b0);
    host_valid = 1'b1; host_cmd = 4'd0;
    tick();
    host_cmd = 4'd3;
    tick();
    host_valid = 1'b0;
    while (cyc < 66) tick();
    checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL flush_early_done: got %b expected 0", seq_done); end
    lcd_done = 1'b1;
    repeat (3) tick();
    lcd_done = 1'b0;
    repeat (3) tick();
    checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL flush_seq_done: got %b expected 1", seq_done); end
    checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", host_ready); end
    checks++; if (issued.size() !== 1) begin errors++; $display("FAIL flush_issue_count: got %0d expected 1", issued.size()); end
    if (issued.size() == 1) begin
      checks++; if (issued[0] !== 4'd0) begin errors++; $display("FAIL flush_cmd: got %0d expected 0", issued[0]); end
    end
    host_valid = 1'b1; host_cmd = 4'd6;
    repeat (2) tick();
    host_valid = 1'b0;
    tick();
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL finish_level: got %0d expected 1", fifo_level); end
  endtask

  // Reset in FLUSH aborts at once, discarding buffered commands
  task automatic test_reset_abort();
    do_reset(1'b1, 1'b0);
    host_valid = 1'b1; host_cmd = 4'd0;
    tick();
    host_cmd = 4'd5;
    tick();
    host_valid = 1'b0;
    repeat (10) tick();
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL abort_pre_level: got %0d expected 1", fifo_level); end
    #2 reset = 1'b1;
    #1;
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL abort_level: got %0d expected 0", fifo_level); end
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", host_ready); end
    tick();
    reset = 1'b0;
    // Sequencer is back in IDLE: a fresh command issues normally
    cyc = 0; issued.delete(); issue_at.delete(); prev_valid = 1'b0;
    host_valid = 1'b1; host_cmd = 4'd2;
    tick();
    host_valid = 1'b0;
    repeat (5) tick();
    checks++; if (issued.size() !== 1) begin errors++; $display("FAIL abort_reissue: got %0d issues expected 1", issued.size()); end
  endtask

`ifdef LCD_CMD_SEQ_TIMEOUT_EN
  // Busy stuck after issuing 2: watchdog ends the sequence after 255 ACK cycles
  task automatic test_timeout();
    do_reset(1'b0, 1'b0);
    host_valid = 1'b1; host_cmd = 4'd2;
    tick();
    host_valid = 1'b0;
    tick();
    lcd_busy = 1'b1;
    // ACK occupies cycles 3..257
    while (cyc < 257) tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", timeout); end
    tick();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b expected 1", timeout); end
    checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL timeout_seq_done: got %b expected 1", seq_done); end
    lcd_busy = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    cyc = 0; rises = 0; err_cnt = 0; err_at = -1;
    prev_valid = 1'b0; busy_model = 1'b0;
    test_reset();
    test_issue_pair();
    test_busy_hold();
    test_fifo_full();
    test_fifo_push_pop_full();
    test_illegal();
    test_flush_finish();
    test_reset_abort();
`ifdef LCD_CMD_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_seq.md
LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high; clock clk.
REQ-003 SHALL have port host_cmd, input, 4, command code from host.
REQ-004 SHALL have port host_valid, input, 1, host_cmd valid this cycle.
REQ-005 SHALL have port host_ready, output, 1, FIFO can accept; a transfer occurs when host_valid and host_ready are both 1.
REQ-006 SHALL have port lcd_cmd, output, 4, registered command to the LCD controller.
REQ-007 SHALL have port lcd_cmd_valid, output, 1, registered one-cycle issue strobe.
REQ-008 SHALL have port lcd_busy, input, 1, LCD controller busy.
REQ-009 SHALL have port lcd_done, input, 1, LCD controller image write-back complete.
REQ-010 SHALL have port seq_done, output, 1, sequence finished; sticky.
REQ-011 SHALL have port err_illegal, output, 1, one-cycle pulse when codes 12..15 are dropped.
REQ-012 SHALL have port fifo_level, output, 4, FIFO occupancy, 0..8.

Function
REQ-013 SHALL buffer host commands in an 8-entry FIFO; host_ready = (level<8) and state!=FINISH.
REQ-014 SHALL apply a simultaneous push and pop in the same cycle without changing level; pointers wrap modulo 8.
REQ-015 SHALL use FSM states IDLE, ISSUE, ACK, FLUSH, FINISH.
REQ-016 IDLE: with FIFO non-empty and lcd_busy=0, SHALL pop the head entry.
- Code 12..15: discard it, pulse err_illegal the next cycle, remain in IDLE.
- Otherwise: load lcd_cmd, go to ISSUE.
REQ-017 ISSUE: lcd_cmd_valid=1 for exactly this one cycle.
- Next state FLUSH if lcd_cmd==0, else ACK.
REQ-018 ACK: wait until lcd_busy=0, then go to IDLE.
- Minimum ACK dwell 1 cycle, covering the busy assertion one cycle after issue.
REQ-019 FLUSH: wait for lcd_done=1, then go to FINISH.
REQ-020 FINISH: terminal state.
- Set seq_done=1; drop all further pushes (host_ready=0).
- Leave FIFO contents unissued.
REQ-021 SHALL keep issue latency, from push into an empty FIFO with lcd_busy=0 and FSM in IDLE, at 2 cycles to lcd_cmd_valid.
REQ-022 SHALL never assert lcd_cmd_valid while lcd_busy=1 in IDLE.
- A head entry waits while lcd_busy stays high, e.g. during the post-reset image load.
REQ-023 SHALL hold lcd_cmd stable from ISSUE until the next issue.

Reset
REQ-024 SHALL, on reset, set the FSM to IDLE, pointers and fifo_level to 0, lcd_cmd to 0, and lcd_cmd_valid, seq_done and err_illegal to 0.
REQ-025 SHALL treat reset asserted mid-sequence, including in FLUSH, as aborting immediately; buffered commands are lost.

Configuration
REQ-026 SHALL implement macro LCD_CMD_SEQ_TIMEOUT_EN.
- Defined: add output timeout (1 bit, reset 0) and an 8-bit watchdog counting cycles in ACK or FLUSH.
- The watchdog clears on any state change.
- On reaching 255: set timeout sticky and force state FINISH.
- Undefined: no port, no counter; ACK and FLUSH wait indefinitely.

Structure
REQ-027 SHALL place in shared package lcd_pkg:
- command code constants: CMD_WRITE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4, MAX=5, MIN=6, AVG=7, CCW=8, CW=9, MIRX=10, MIRY=11;
- the FSM state enum;
- FIFO depth constant 8.
REQ-028 SHALL implement the FIFO as sub-module lcd_cmd_fifo (sync, 4-bit data, depth 8, level output); the FSM is in the top.

Verification
REQ-029 Push 4,1 with lcd_busy=0 and model busy high 1 cycle per command -> lcd_cmd_valid pulses twice, carrying 4 then 1, each 1 cycle wide.
REQ-030 Hold lcd_busy=1 for 70 cycles after reset and push 5 -> no lcd_cmd_valid until busy falls; issue 2 cycles after the fall.
REQ-031 Push 8 entries with busy held 1 -> fifo_level=8, host_ready=0, ninth push ignored; simultaneous push and pop at 8 keeps level 8.
REQ-032 Push 13 then 7 -> err_illegal single pulse, only lcd_cmd=7 issued.
REQ-033 Push 0 then 3, with lcd_done high 66 cycles later -> lcd_cmd=0 issued, seq_done=1, command 3 never issued, host_ready=0.
REQ-034 With LCD_CMD_SEQ_TIMEOUT_EN, push 2 and hold lcd_busy=1 -> timeout=1 after 255 cycles in ACK, seq_done=1.
